systolic_controll_gen: RTL

- Parametrised next-generation sequencer for the weight-stationary systolic array.
- Sequences LOAD, WAIT and ROLLING phases. Drives the SRAM address serial number, ALU start, cycle count, output matrix index and data-set index.
- Supports a runtime data-set count, SRAM stall back-pressure and abort.
- Sits between the top-level TPU start/done handshake, the address selector, the systolic array and the write-out SRAM.

---
 rtl/systolic_controll_gen_pkg.sv | 51 +++++
 rtl/systolic_controll_gen_if.sv | 46 ++++
 rtl/systolic_controll_gen_out_counter.sv | 59 +++++
 rtl/systolic_controll_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/systolic_controll_gen_pkg.sv
// -----------------------------------------------------------------------------
// systolic_ctrl_pkg
//   Shared definitions for the weight-stationary systolic array sequencer:
//   state encoding, width/size helper functions and the data-set clamp.
//   No ports (package).
// -----------------------------------------------------------------------------
package systolic_ctrl_pkg;

    // Sequencer states, kept as plain 2-bit constants so that legacy code
    // and waveform scripts that expect raw codes keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ROLL = 2'd3;

    // Named view of the same codes for tools and debug displays.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        WAIT = ST_WAIT,
        ROLL = ST_ROLL
    } state_e;

    // Each data set produces two outputs per PE row.
    function automatic int calc_out_per_set(input int array_size);
        return 2 * array_size;
    endfunction

    // Width of the output index inside one set.
    function automatic int calc_idx_w(input int out_per_set);
        return (out_per_set > 1) ? $clog2(out_per_set) : 1;
    endfunction

    // Width of the data-set index; never narrower than one bit.
    function automatic int calc_set_w(input int max_sets);
        return (max_sets > 1) ? $clog2(max_sets) : 1;
    endfunction

    // Runtime set count: zero is treated as one, anything above the
    // maximum is limited to the maximum.
    function automatic int clamp_sets(input int cfg, input int max_sets);
        if (cfg < 1) begin
            return 1;
        end
        if (cfg > max_sets) begin
            return max_sets;
        end
        return cfg;
    endfunction

endpackage

// File: rtl/systolic_controll_gen_if.sv
// -----------------------------------------------------------------------------
// systolic_controll_gen_if
//   Bundles the start/done handshake, run configuration, SRAM back-pressure
//   and the sequencer outputs toward the array and the write-out SRAM.
//   master : host side (drives tpu_start, cfg_num_sets, stall, abort)
//   slave  : sequencer side (drives sram_write_enable, addr_serial_num,
//            alu_start, cycle_num, matrix_index, data_set, tpu_busy, tpu_done)
// -----------------------------------------------------------------------------
interface systolic_controll_gen_if #(
    parameter int ARRAY_SIZE = 8,
    parameter int MAX_SETS   = 4,
    parameter int ADDR_W     = 7,
    parameter int CYC_W      = 9
);
    import systolic_ctrl_pkg::*;

    localparam int OUT_PER_SET = calc_out_per_set(ARRAY_SIZE);
    localparam int IDX_W       = calc_idx_w(OUT_PER_SET);
    localparam int SET_W       = calc_set_w(MAX_SETS);

    logic              tpu_start;
    logic [SET_W:0]    cfg_num_sets;
    logic              stall;
    logic              abort;
    logic              sram_write_enable;
    logic [ADDR_W-1:0] addr_serial_num;
    logic              alu_start;
    logic [CYC_W-1:0]  cycle_num;
    logic [IDX_W-1:0]  matrix_index;
    logic [SET_W-1:0]  data_set;
    logic              tpu_busy;
    logic              tpu_done;

    modport master (
        output tpu_start, cfg_num_sets, stall, abort,
        input  sram_write_enable, addr_serial_num, alu_start, cycle_num,
               matrix_index, data_set, tpu_busy, tpu_done
    );

    modport slave (
        input  tpu_start, cfg_num_sets, stall, abort,
        output sram_write_enable, addr_serial_num, alu_start, cycle_num,
               matrix_index, data_set, tpu_busy, tpu_done
    );

endinterface

// File: rtl/systolic_controll_gen_out_counter.sv
// -----------------------------------------------------------------------------
// systolic_out_counter
//   Output position tracker: matrix_index counts writes inside a set and wraps
//   into the data-set index. Flags the final write position of the run.
//   clk, arst    : clock, asynchronous active-high reset
//   i_clr        : clear both indices (has priority over i_inc)
//   i_inc        : advance by one write
//   i_last_set   : index of the final set of this run (num_sets-1)
//   o_idx, o_set : current output index / set index
//   o_last       : current position is the final write of the run
// -----------------------------------------------------------------------------
module systolic_out_counter
    import systolic_ctrl_pkg::*;
#(
    parameter  int OUT_PER_SET = 16,
    parameter  int MAX_SETS    = 4,
    localparam int IDX_W       = calc_idx_w(OUT_PER_SET),
    localparam int SET_W       = calc_set_w(MAX_SETS)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [SET_W-1:0] i_last_set,
    output logic [IDX_W-1:0] o_idx,
    output logic [SET_W-1:0] o_set,
    output logic             o_last
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_PER_SET - 1);

    logic [IDX_W-1:0] r_idx;
    logic [SET_W-1:0] r_set;

    assign o_idx  = r_idx;
    assign o_set  = r_set;
    assign o_last = (r_idx == IDX_LAST) && (r_set == i_last_set);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_idx <= '0;
            r_set <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
            r_set <= '0;
        end else if (i_inc) begin
            if (r_idx == IDX_LAST) begin
                r_idx <= '0;
                // The set index stays on the final set after the last write,
                // so it never runs past num_sets-1.
                if (!o_last) begin
                    r_set <= r_set + 1'b1;
                end
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_controll_gen.sv
// -----------------------------------------------------------------------------
// systolic_controll_gen
//   Sequencer for the weight-stationary systolic array. A run goes
//   IDLE -> LOAD -> WAIT -> ROLL -> IDLE. During ROLL the array is clocked
//   (alu_start), the input-SRAM address and cycle counter advance, and once
//   the pipeline is full every cycle writes one output, num_sets*2*ARRAY_SIZE
//   outputs in total. stall freezes ROLL; abort cancels the run.
//   clk  : clock
//   arst : asynchronous active-high reset
//   bus  : slave side of systolic_controll_gen_if (handshake, config,
//          stall/abort in; SRAM strobe, address, counters, busy/done out)
// -----------------------------------------------------------------------------
module systolic_controll_gen
    import systolic_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE = 8,
    parameter int MAX_SETS   = 4,
    parameter int ADDR_W     = 7,
    parameter int CYC_W      = 9
) (
    input  logic                   clk,
    input  logic                   arst,
    systolic_controll_gen_if.slave bus
);
    localparam int OUT_PER_SET = calc_out_per_set(ARRAY_SIZE);
    localparam int IDX_W       = calc_idx_w(OUT_PER_SET);
    localparam int SET_W       = calc_set_w(MAX_SETS);
    localparam int NS_W        = SET_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [CYC_W-1:0]  CYC_MAX   = '1;
    // First cycle_num value at which the array has produced a valid output.
    localparam logic [CYC_W-1:0]  WIN_START = CYC_W'(ARRAY_SIZE + 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CYC_W-1:0]  r_cycle;
    logic [NS_W-1:0]   r_num_sets;
    logic              r_done;

    logic              w_idle;
    logic              w_roll;
    logic              w_accept;
    logic              w_abort;
    logic              w_we;
    logic              w_cnt_clr;
    logic              w_cnt_last;
    logic              w_last_write;
    logic [SET_W-1:0]  w_last_set;
    logic [IDX_W-1:0]  w_idx;
    logic [SET_W-1:0]  w_set;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_roll   = (r_state == ST_ROLL);
    // abort in IDLE only blocks a start; in a busy state it ends the run.
    assign w_accept = w_idle && bus.tpu_start && !bus.abort;
    assign w_abort  = !w_idle && bus.abort;

    assign w_we         = w_roll && !bus.stall && !bus.abort && (r_cycle >= WIN_START);
    assign w_last_write = w_we && w_cnt_last;
    assign w_last_set   = SET_W'(r_num_sets - 1'b1);
    // Indices restart for every run when entering ROLL, and on abort.
    assign w_cnt_clr    = w_abort || (r_state == ST_WAIT);

    assign bus.sram_write_enable = w_we;
    assign bus.alu_start         = w_roll && !bus.stall;
    assign bus.tpu_busy          = !w_idle;
    assign bus.tpu_done          = r_done;
    assign bus.addr_serial_num   = r_addr;
    assign bus.cycle_num         = r_cycle;
    assign bus.matrix_index      = w_idx;
    assign bus.data_set          = w_set;

    systolic_out_counter #(
        .OUT_PER_SET (OUT_PER_SET),
        .MAX_SETS    (MAX_SETS)
    ) u_out_cnt (
        .clk        (clk),
        .arst       (arst),
        .i_clr      (w_cnt_clr),
        .i_inc      (w_we),
        .i_last_set (w_last_set),
        .o_idx      (w_idx),
        .o_set      (w_set),
        .o_last     (w_cnt_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = w_abort ? ST_IDLE : ST_WAIT;
            ST_WAIT: w_state_nxt = w_abort ? ST_IDLE : ST_ROLL;
            ST_ROLL: if (w_abort || w_last_write) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_write;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_addr     <= '0;
            r_cycle    <= '0;
            r_num_sets <= NS_W'(1);
        end else if (w_abort) begin
            r_addr  <= '0;
            r_cycle <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= '0;
                        r_num_sets <= NS_W'(clamp_sets(int'(bus.cfg_num_sets), MAX_SETS));
                    end
                end
                ST_LOAD: r_addr <= ADDR_W'(1);
                ST_WAIT: begin
                    r_addr  <= ADDR_W'(2);
                    r_cycle <= '0;
                end
                ST_ROLL: begin
                    if (!bus.stall) begin
                        if (r_addr != ADDR_MAX) r_addr <= r_addr + 1'b1;
                        if (r_cycle != CYC_MAX) r_cycle <= r_cycle + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
